fcw_voice_scheduler: RTL and testbench
======================================

FCW_VOICE_SCHEDULER -- requirements
Module: fcw_voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, meaning the number of polyphonic oscillator voices sharing one FCW lookup table.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port ev_valid, input, 1, note event present.
REQ-005 SHALL have port ev_ready, output, 1, scheduler can accept an event.
REQ-006 SHALL have port ev_note, input, 7, note number (valid 7'h01..7'h58).
REQ-007 SHALL have port ev_on, input, 1, 1 = note-on, 0 = note-off.
REQ-008 SHALL have port fcw_addr, output, 7, address to the shared combinational FCW table.
REQ-009 SHALL have port fcw, input, 24, FCW returned by the table for fcw_addr.
REQ-010 SHALL have port voice_fcw, output, NUM_VOICES*24, per-voice FCW; voice i at bits [24i+23:24i].
REQ-011 SHALL have port voice_gate, output, NUM_VOICES, per-voice note-active flag.

Function
REQ-012 SHALL implement FSM IDLE -> LOOKUP -> WRITE -> IDLE.
REQ-013 SHALL assert ev_ready only in IDLE; an event is accepted on an edge with ev_valid && ev_ready, latching ev_note and ev_on.
REQ-014 SHALL hold fcw_addr = 0 in IDLE and fcw_addr = latched note in LOOKUP and WRITE.
REQ-015 SHALL pick the target voice in LOOKUP, with priority: gated voice holding the same note (retrigger) > lowest-index ungated voice > least-recently-allocated voice (steal).
REQ-016 For note-on, SHALL, on the edge ending WRITE, load fcw into the target voice, set its gate, and store its note; outputs SHALL be visible 3 cycles after the accept edge.
REQ-017 For note-off, SHALL clear the gate of the gated voice holding the note on the edge ending WRITE; voice_fcw SHALL be retained; with no match, SHALL change nothing.
REQ-018 SHALL accept events with note 7'h00 or > 7'h58 and pass them through the full FSM sequence, but SHALL change no voice state for them.
REQ-019 SHALL keep an LRU rank per voice (0 = newest); on allocation the target voice gets rank 0 and voices with a lower old rank increment; ranks SHALL remain a permutation of 0..NUM_VOICES-1.
REQ-020 SHALL make retrigger refresh the FCW and set rank 0; steal SHALL overwrite the voice's note and FCW without dropping its gate.
REQ-021 SHALL make throughput at most one event per 3 cycles; ev_valid held high SHALL be accepted again in the cycle after WRITE.

Reset
REQ-022 SHALL, on reset, force state IDLE, ev_ready=1, fcw_addr=0, voice_fcw=0, voice_gate=0, stored notes=0, and ranks = voice index.
REQ-023 SHALL make reset asserted mid-sequence abandon the event immediately, with no partial voice update.

Structure
REQ-024 SHALL take NOTE_W=7, FCW_W=24, MAX_NOTE=7'h58 and the FSM state enum from shared package organ_pkg.
REQ-025 SHALL place LRU rank tracking in sub-module voice_lru (inputs: touch, touch_idx; output: oldest_idx).
REQ-026 SHALL connect the FCW table externally through fcw_addr/fcw, not instantiate it internally.

Verification
REQ-027 Note-on 7'h31 after reset: voice_fcw[0] = 24'h0258bf and voice_gate = 4'b0001 at accept+3; ev_ready low for exactly 2 cycles.
REQ-028 Note-on 7'h01, 7'h0c, 7'h18, 7'h24, then 7'h58: the fifth event steals voice 0 -> voice_fcw[0] = 24'h16534c, gate stays 4'b1111.
REQ-029 Note-on 7'h40, then note-off 7'h40: voice_gate returns to 0 and voice_fcw[0] stays 24'h0594d2; a note-off for an unused note changes nothing.
REQ-030 Note-on 7'h00 and 7'h7f: accepted with ready cycling, and voice_fcw/voice_gate remain unchanged.
REQ-031 Reset asserted in LOOKUP of note-on 7'h31: all outputs immediately reset values, and no voice is updated after release.
REQ-032 Back-to-back ev_valid held high with 6 events: acceptance every third cycle, and ranks remain a valid permutation throughout.

Source files
------------

// File: rtl/organ_pkg.sv
// Shared widths, limits and scheduler FSM states for the organ voice path.
// Imported by the FCW voice scheduler and its LRU helper.
package organ_pkg;

    localparam int NOTE_W = 7;
    localparam int FCW_W  = 24;

    localparam logic [NOTE_W-1:0] MAX_NOTE = 7'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITE
    } sched_state_t;

    // Notes outside 1..MAX_NOTE run the FSM but never touch a voice.
    function automatic logic note_in_range(input logic [NOTE_W-1:0] n);
        return (n != '0) && (n <= MAX_NOTE);
    endfunction

endpackage

// File: rtl/voice_lru.sv
// Least-recently-allocated tracking: one rank per voice, 0 = newest.
// Ranks always form a permutation of 0..NUM_VOICES-1.
module voice_lru
    import organ_pkg::*;
#(
    parameter int  NUM_VOICES = 4,
    localparam int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             touch,
    input  logic [IDX_W-1:0] touch_idx,
    output logic [IDX_W-1:0] oldest_idx
);

    logic [IDX_W-1:0] rank [NUM_VOICES];
    logic [IDX_W-1:0] touched_rank;

    assign touched_rank = rank[touch_idx];

    // Touched voice becomes newest; voices newer than it age by one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank[i] <= IDX_W'(i);
            end
        end else if (touch) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (touch_idx == IDX_W'(i)) begin
                    rank[i] <= '0;
                end else if (rank[i] < touched_rank) begin
                    rank[i] <= rank[i] + 1'b1;
                end
            end
        end
    end

    // The voice holding the highest rank is the steal candidate.
    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank[i] == IDX_W'(NUM_VOICES - 1)) begin
                oldest_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fcw_voice_scheduler.sv
// Polyphonic note-event scheduler sharing one external FCW table.
// Each event runs IDLE -> LOOKUP -> WRITE; voices update when WRITE ends.
module fcw_voice_scheduler
    import organ_pkg::*;
#(
    parameter int  NUM_VOICES = 4,
    localparam int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic [NOTE_W-1:0]           ev_note,
    input  logic                        ev_on,
    output logic [NOTE_W-1:0]           fcw_addr,
    input  logic [FCW_W-1:0]            fcw,
    output logic [NUM_VOICES*FCW_W-1:0] voice_fcw,
    output logic [NUM_VOICES-1:0]       voice_gate
);

    sched_state_t      state;
    logic [NOTE_W-1:0] note_q;
    logic              on_q;
    logic [IDX_W-1:0]  tgt_idx;
    logic              tgt_commit;

    logic [NOTE_W-1:0] voice_note [NUM_VOICES];

    logic              match_found;
    logic [IDX_W-1:0]  match_idx;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  oldest_idx;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_commit;
    logic              touch;

    // Find lowest-index gated voice with the latched note, and lowest free voice.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_gate[i] && (voice_note[i] == note_q)) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (!voice_gate[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Target choice: retrigger, else free voice, else steal the oldest.
    always_comb begin
        pick_idx    = match_idx;
        pick_commit = 1'b0;
        if (note_in_range(note_q)) begin
            if (on_q) begin
                pick_commit = 1'b1;
                if (match_found) begin
                    pick_idx = match_idx;
                end else if (free_found) begin
                    pick_idx = free_idx;
                end else begin
                    pick_idx = oldest_idx;
                end
            end else begin
                pick_commit = match_found;
                pick_idx    = match_idx;
            end
        end
    end

    // Event sequencing with registered handshake and table address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ev_ready   <= 1'b1;
            fcw_addr   <= '0;
            note_q     <= '0;
            on_q       <= 1'b0;
            tgt_idx    <= '0;
            tgt_commit <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ev_valid && ev_ready) begin
                        note_q   <= ev_note;
                        on_q     <= ev_on;
                        fcw_addr <= ev_note;
                        ev_ready <= 1'b0;
                        state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    tgt_idx    <= pick_idx;
                    tgt_commit <= pick_commit;
                    state      <= ST_WRITE;
                end
                ST_WRITE: begin
                    tgt_commit <= 1'b0;
                    fcw_addr   <= '0;
                    ev_ready   <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    fcw_addr <= '0;
                    ev_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign touch = (state == ST_WRITE) && tgt_commit && on_q;

    // Voice update on the edge that ends WRITE; note-off keeps the FCW.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            voice_fcw  <= '0;
            voice_gate <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_note[i] <= '0;
            end
        end else if ((state == ST_WRITE) && tgt_commit) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (tgt_idx == IDX_W'(i)) begin
                    if (on_q) begin
                        voice_fcw[i*FCW_W +: FCW_W] <= fcw;
                        voice_gate[i]               <= 1'b1;
                        voice_note[i]               <= note_q;
                    end else begin
                        voice_gate[i] <= 1'b0;
                    end
                end
            end
        end
    end

    voice_lru #(
        .NUM_VOICES (NUM_VOICES)
    ) u_lru (
        .clk        (clk),
        .reset      (reset),
        .touch      (touch),
        .touch_idx  (tgt_idx),
        .oldest_idx (oldest_idx)
    );

endmodule

// File: tb/tb_fcw_voice_scheduler.sv
// Directed bench for fcw_voice_scheduler with an external FCW table model.
// Table-driven event vectors plus reset and back-to-back sequences.
module tb_fcw_voice_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        ev_valid;
    logic        ev_ready;
    logic [6:0]  ev_note;
    logic        ev_on;
    logic [6:0]  fcw_addr;
    logic [23:0] fcw;
    logic [95:0] voice_fcw;
    logic [3:0]  voice_gate;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [23:0] fcw_of(input logic [6:0] n);
        case (n)
            7'h31:   return 24'h0258bf;
            7'h40:   return 24'h0594d2;
            7'h58:   return 24'h16534c;
            default: return {1'b0, n, 16'h1234};
        endcase
    endfunction

    assign fcw = fcw_of(fcw_addr);

    fcw_voice_scheduler #(.NUM_VOICES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_note    (ev_note),
        .ev_on      (ev_on),
        .fcw_addr   (fcw_addr),
        .fcw        (fcw),
        .voice_fcw  (voice_fcw),
        .voice_gate (voice_gate)
    );

    typedef struct {
        logic [6:0]  note;
        logic        on;
        logic [3:0]  gate;
        logic [95:0] vfcw;
        logic [7:0]  rank;
    } vec_t;

    vec_t tv [17];

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ranks_now();
        return {dut.u_lru.rank[3], dut.u_lru.rank[2],
                dut.u_lru.rank[1], dut.u_lru.rank[0]};
    endfunction

    function automatic logic perm_ok();
        logic [3:0] seen;
        seen = '0;
        for (int i = 0; i < 4; i++) seen[dut.u_lru.rank[i]] = 1'b1;
        return seen == 4'hf;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx,
                         input logic [3:0] pg, input logic [95:0] pf);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        ev_valid = 1'b1;
        ev_note  = v.note;
        ev_on    = v.on;
        chk({tag, "_ready_idle"}, 96'(ev_ready), 96'd1);
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        chk({tag, "_ready_lookup"}, 96'(ev_ready), 96'd0);
        chk({tag, "_addr_lookup"}, 96'(fcw_addr), 96'(v.note));
        chk({tag, "_gate_early"}, 96'(voice_gate), 96'(pg));
        @(posedge clk);
        #1;
        chk({tag, "_ready_write"}, 96'(ev_ready), 96'd0);
        chk({tag, "_fcw_early"}, voice_fcw, pf);
        @(posedge clk);
        #1;
        chk({tag, "_ready_back"}, 96'(ev_ready), 96'd1);
        chk({tag, "_addr_idle"}, 96'(fcw_addr), 96'd0);
        chk({tag, "_gate"}, 96'(voice_gate), 96'(v.gate));
        chk({tag, "_fcw"}, voice_fcw, v.vfcw);
        chk({tag, "_rank"}, 96'(ranks_now()), 96'(v.rank));
    endtask

    initial begin
        logic [23:0] z;
        logic [3:0]  pg;
        logic [95:0] pf;
        logic [6:0]  bb_note [6];
        int          acc [6];
        int          k;
        int          cyc;

        z = 24'h0;
        tv[0]  = '{7'h31, 1'b1, 4'b0001, {z, z, z, fcw_of(7'h31)}, 8'he4};
        tv[1]  = '{7'h31, 1'b0, 4'b0000, {z, z, z, fcw_of(7'h31)}, 8'he4};
        tv[2]  = '{7'h40, 1'b1, 4'b0001, {z, z, z, fcw_of(7'h40)}, 8'he4};
        tv[3]  = '{7'h40, 1'b0, 4'b0000, {z, z, z, fcw_of(7'h40)}, 8'he4};
        tv[4]  = '{7'h22, 1'b0, 4'b0000, {z, z, z, fcw_of(7'h40)}, 8'he4};
        tv[5]  = '{7'h00, 1'b1, 4'b0000, {z, z, z, fcw_of(7'h40)}, 8'he4};
        tv[6]  = '{7'h7f, 1'b1, 4'b0000, {z, z, z, fcw_of(7'h40)}, 8'he4};
        tv[7]  = '{7'h01, 1'b1, 4'b0001, {z, z, z, fcw_of(7'h01)}, 8'he4};
        tv[8]  = '{7'h0c, 1'b1, 4'b0011,
                   {z, z, fcw_of(7'h0c), fcw_of(7'h01)}, 8'he1};
        tv[9]  = '{7'h18, 1'b1, 4'b0111,
                   {z, fcw_of(7'h18), fcw_of(7'h0c), fcw_of(7'h01)}, 8'hc6};
        tv[10] = '{7'h24, 1'b1, 4'b1111,
                   {fcw_of(7'h24), fcw_of(7'h18), fcw_of(7'h0c),
                    fcw_of(7'h01)}, 8'h1b};
        tv[11] = '{7'h58, 1'b1, 4'b1111,
                   {fcw_of(7'h24), fcw_of(7'h18), fcw_of(7'h0c),
                    24'h16534c}, 8'h6c};
        tv[12] = '{7'h0c, 1'b1, 4'b1111,
                   {fcw_of(7'h24), fcw_of(7'h18), fcw_of(7'h0c),
                    24'h16534c}, 8'hb1};
        tv[13] = '{7'h18, 1'b0, 4'b1011,
                   {fcw_of(7'h24), fcw_of(7'h18), fcw_of(7'h0c),
                    24'h16534c}, 8'hb1};
        tv[14] = '{7'h31, 1'b1, 4'b1111,
                   {fcw_of(7'h24), 24'h0258bf, fcw_of(7'h0c),
                    24'h16534c}, 8'hc6};
        tv[15] = '{7'h7f, 1'b1, 4'b1111,
                   {fcw_of(7'h24), 24'h0258bf, fcw_of(7'h0c),
                    24'h16534c}, 8'hc6};
        tv[16] = '{7'h40, 1'b1, 4'b1111,
                   {24'h0594d2, 24'h0258bf, fcw_of(7'h0c),
                    24'h16534c}, 8'h1b};

        ev_valid = 1'b0;
        ev_note  = '0;
        ev_on    = 1'b0;
        reset    = 1'b1;
        #3;
        chk("rst_ready", 96'(ev_ready), 96'd1);
        chk("rst_addr", 96'(fcw_addr), 96'd0);
        chk("rst_gate", 96'(voice_gate), 96'd0);
        chk("rst_fcw", voice_fcw, 96'd0);
        chk("rst_rank", 96'(ranks_now()), 96'h0e4);
        do_reset();

        pg = '0;
        pf = '0;
        for (int i = 0; i < 17; i++) begin
            apply(tv[i], i, pg, pf);
            chk($sformatf("v%0d_perm", i), 96'(perm_ok()), 96'd1);
            pg = tv[i].gate;
            pf = tv[i].vfcw;
        end

        do_reset();
        @(negedge clk);
        ev_valid = 1'b1;
        ev_note  = 7'h31;
        ev_on    = 1'b1;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        chk("mid_in_lookup", 96'(fcw_addr), 96'h31);
        reset = 1'b1;
        #1;
        chk("mid_ready", 96'(ev_ready), 96'd1);
        chk("mid_addr", 96'(fcw_addr), 96'd0);
        chk("mid_gate", 96'(voice_gate), 96'd0);
        chk("mid_fcw", voice_fcw, 96'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_after_gate", 96'(voice_gate), 96'd0);
        chk("mid_after_fcw", voice_fcw, 96'd0);
        chk("mid_after_rank", 96'(ranks_now()), 96'h0e4);

        bb_note[0] = 7'h10;
        bb_note[1] = 7'h11;
        bb_note[2] = 7'h12;
        bb_note[3] = 7'h13;
        bb_note[4] = 7'h14;
        bb_note[5] = 7'h15;
        k   = 0;
        cyc = 0;
        @(negedge clk);
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = bb_note[0];
        while (k < 6 && cyc < 60) begin
            if (ev_ready) begin
                acc[k] = cyc;
                k++;
            end
            @(posedge clk);
            #1;
            chk($sformatf("bb_perm_c%0d", cyc), 96'(perm_ok()), 96'd1);
            @(negedge clk);
            cyc++;
            if (k < 6) ev_note = bb_note[k];
            else ev_valid = 1'b0;
        end
        ev_valid = 1'b0;
        chk("bb_accepts", 96'(k), 96'd6);
        for (int i = 1; i < 6; i++) begin
            if (i < k) begin
                chk($sformatf("bb_gap%0d", i), 96'(acc[i] - acc[i-1]), 96'd3);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("bb_gate", 96'(voice_gate), 96'hf);
        chk("bb_fcw", voice_fcw,
            {fcw_of(7'h13), fcw_of(7'h12), fcw_of(7'h15), fcw_of(7'h14)});
        chk("bb_rank", 96'(ranks_now()), 96'h0b1);
        chk("bb_ready", 96'(ev_ready), 96'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
